// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store data (D).
// Grants are combinational (one per cycle); a single in-flight read is tracked with a fixed-latency counter.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_rden,
    output logic            mem_wren,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata
);

    localparam logic [1:0] LAT  = 2'(MEM_LAT);
    localparam logic [3:0] WMAX = 4'(MAX_WAIT);

    logic [1:0] lat_cnt;
    logic       owner;
    logic [3:0] wait_cnt;
    logic       port_free;
    logic       if_boost;

    // Port frees up in the return cycle (lat_cnt == 1) so reads can issue back-to-back.
    always_comb begin
        port_free = !rst && (lat_cnt <= 2'd1);
        if_boost  = if_req && (wait_cnt == WMAX);
        if_gnt    = port_free && if_req && (if_boost || !d_req);
        d_gnt     = port_free && d_req && !if_boost;
        mem_rden  = if_gnt | (d_gnt & ~d_we);
        mem_wren  = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
            mem_be   = '1;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_we ? d_be : '1;
        end
        if_rvalid = !rst && (lat_cnt == 2'd1) && !owner;
        d_rvalid  = !rst && (lat_cnt == 2'd1) && owner;
    end

    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt  <= 2'd0;
            owner    <= 1'b0;
            wait_cnt <= 4'd0;
        end else begin
            if (mem_rden) begin
                lat_cnt <= LAT;
                owner   <= d_gnt;
            end else if (lat_cnt != 2'd0) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
            // Starvation counter only runs while IF keeps asking and keeps losing.
            if (if_gnt || !if_req) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != WMAX) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT = 1, 2, 3) each with a small RAM,
// checked every cycle against a cycle-number based reference model.
module tb_mem_port_arbiter;

    localparam int N        = 3;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req    [N];
    logic [31:0] if_addr   [N];
    logic        if_gnt    [N];
    logic        if_rvalid [N];
    logic [31:0] if_rdata  [N];
    logic        d_req     [N];
    logic        d_we      [N];
    logic [31:0] d_addr    [N];
    logic [31:0] d_wdata   [N];
    logic [3:0]  d_be      [N];
    logic        d_gnt     [N];
    logic        d_rvalid  [N];
    logic [31:0] d_rdata   [N];
    logic        mem_rden  [N];
    logic        mem_wren  [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [3:0]  mem_be    [N];
    logic [31:0] mem_rdata [N];

    function automatic logic [31:0] init_word(int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [31:0] ram [256];
        logic [31:0] p1, p2, p3;

        initial for (int i = 0; i < 256; i++) ram[i] = init_word(i);

        always @(posedge clk) begin
            if (mem_wren[g])
                for (int b = 0; b < 4; b++)
                    if (mem_be[g][b]) ram[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            p1 <= mem_rden[g] ? ram[mem_addr[g][9:2]] : 32'hBAD0_0000;
            p2 <= p1;
            p3 <= p2;
        end
        assign mem_rdata[g] = (g == 0) ? p1 : (g == 1) ? p2 : p3;

        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(g + 1), .MAX_WAIT(MAX_WAIT)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_be(d_be[g]), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
            .mem_rden(mem_rden[g]), .mem_wren(mem_wren[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_be(mem_be[g]), .mem_rdata(mem_rdata[g])
        );
    end

    // Reference model state, expressed in absolute cycle numbers.
    int          cyc;
    int          ntests = 0;
    int          nfail  = 0;
    int          busy_until [N];
    int          due        [N];
    int          wstart     [N];
    logic        own        [N];
    logic [31:0] edata      [N];
    logic [31:0] shadow     [N][256];
    logic        gi_seen    [N];
    logic        gd_seen    [N];
    int          run        [N];
    int          last_run   [N];

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic set_if(int k, logic [31:0] a);
        if_req[k]  = 1'b1;
        if_addr[k] = a;
    endtask

    task automatic set_d(int k, logic we, logic [31:0] a, logic [31:0] w, logic [3:0] be);
        d_req[k]   = 1'b1;
        d_we[k]    = we;
        d_addr[k]  = a;
        d_wdata[k] = w;
        d_be[k]    = be;
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            int          lat;
            int          wcnt;
            logic        free, egi, egd, erd, ewr, eirv, edrv;
            logic [31:0] ea, ew;
            logic [3:0]  eb;
            lat  = k + 1;
            free = !rst && (cyc >= busy_until[k]);
            if (wstart[k] < 0) wcnt = 0;
            else wcnt = (cyc - wstart[k] > MAX_WAIT) ? MAX_WAIT : cyc - wstart[k];
            egi  = free && if_req[k] && (wcnt == MAX_WAIT || !d_req[k]);
            egd  = free && d_req[k] && !egi;
            erd  = egi || (egd && !d_we[k]);
            ewr  = egd && d_we[k];
            ea   = egi ? if_addr[k] : (egd ? d_addr[k] : 32'd0);
            ew   = egd ? d_wdata[k] : 32'd0;
            eb   = egi ? 4'hF : (egd ? (d_we[k] ? d_be[k] : 4'hF) : 4'h0);
            eirv = !rst && (cyc == due[k]) && !own[k];
            edrv = !rst && (cyc == due[k]) && own[k];

            chk("if_gnt", k, 32'(if_gnt[k]), 32'(egi));
            chk("d_gnt", k, 32'(d_gnt[k]), 32'(egd));
            chk("mem_rden", k, 32'(mem_rden[k]), 32'(erd));
            chk("mem_wren", k, 32'(mem_wren[k]), 32'(ewr));
            chk("mem_addr", k, mem_addr[k], ea);
            chk("mem_wdata", k, mem_wdata[k], ew);
            chk("mem_be", k, 32'(mem_be[k]), 32'(eb));
            chk("if_rvalid", k, 32'(if_rvalid[k]), 32'(eirv));
            chk("d_rvalid", k, 32'(d_rvalid[k]), 32'(edrv));
            if (eirv) chk("if_rdata", k, if_rdata[k], edata[k]);
            if (edrv) chk("d_rdata", k, d_rdata[k], edata[k]);

            // Length of each IF request run as seen on the DUT's grant.
            if (!if_req[k]) run[k] = 0;
            else begin
                run[k]++;
                if (if_gnt[k] === 1'b1) begin
                    last_run[k] = run[k];
                    run[k] = 0;
                end
            end

            gi_seen[k] = egi;
            gd_seen[k] = egd;
            if (rst) begin
                busy_until[k] = 0;
                due[k]        = -1;
                wstart[k]     = -1;
            end else begin
                if (erd) begin
                    busy_until[k] = cyc + lat;
                    due[k]        = cyc + lat;
                    own[k]        = egd;
                    edata[k]      = shadow[k][ea[9:2]];
                end
                if (ewr)
                    for (int b = 0; b < 4; b++)
                        if (eb[b]) shadow[k][ea[9:2]][8*b +: 8] = ew[8*b +: 8];
                if (if_req[k] && !egi) begin
                    if (wstart[k] < 0) wstart[k] = cyc;
                end else begin
                    wstart[k] = -1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (gi_seen[k]) if_req[k] = 1'b0;
            if (gd_seen[k]) d_req[k] = 1'b0;
        end
    endtask

    initial begin
        cyc = 0;
        for (int k = 0; k < N; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0; d_be[k] = '0;
            busy_until[k] = 0; due[k] = -1; wstart[k] = -1; own[k] = 1'b0; edata[k] = '0;
            run[k] = 0; last_run[k] = 0;
            for (int i = 0; i < 256; i++) shadow[k][i] = init_word(i);
        end

        // Reset with requests pending: nothing may be granted.
        rst = 1'b1;
        set_if(0, 32'h0000_0010);
        set_d(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        tick();
        tick();
        if_req[0] = 1'b0;
        d_req[1]  = 1'b0;
        rst = 1'b0;
        tick();

        // Fetch alone at 0x40.
        set_if(0, 32'h0000_0040);
        tick(); tick(); tick();

        // Fetch and load together: load first, fetch next cycle.
        set_if(0, 32'h0000_0044);
        set_d(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        tick(); tick(); tick(); tick();

        // Continuous loads must not starve fetch beyond MAX_WAIT.
        set_if(0, 32'h0000_0048);
        for (int i = 0; i < 10; i++) begin
            if (!d_req[0]) set_d(0, 1'b0, 32'h0000_0200 + 32'(4 * i), 32'h0, 4'h0);
            tick();
        end
        d_req[0] = 1'b0;
        tick(); tick();
        chk("starve_run", 0, 32'(last_run[0]), 32'(MAX_WAIT + 1));

        // Partial store, then fetch of the same word the following cycle.
        set_d(0, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 4'b0011);
        tick();
        set_if(0, 32'h0000_0080);
        tick(); tick(); tick();

        // MEM_LAT=3: port held for two cycles after a load grant.
        set_d(2, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
        tick();
        set_if(2, 32'h0000_0304);
        tick(); tick(); tick(); tick(); tick(); tick();

        // MEM_LAT=2: reset while a read is in flight drops the return.
        set_d(1, 1'b0, 32'h0000_0140, 32'h0, 4'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick(); tick();

        // Random traffic on all three instances.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!if_req[k] && $urandom_range(0, 2) == 0)
                    set_if(k, {22'd0, 8'($urandom_range(0, 255)), 2'b00});
                if (!d_req[k] && $urandom_range(0, 1) == 0)
                    set_d(k, 1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                          $urandom, 4'($urandom_range(0, 15)));
            end
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
